data_memory_unit: RTL and testbench

//  Memory stage directly downstream of the ALU in the single-cycle LEGv8 datapath.
//  - ALU result is the byte address; register-file read data 2 is the store data.
//  - Byte-addressed, little-endian, doubleword-organised RAM.
//  - Stores are byte-lane merged at the clock edge; loads are combinational, with zero/sign extension.
//  - A sticky error flag records any illegal access.

---
 rtl/data_memory_unit.sv | 101 ++++++++++
 tb/tb_data_memory_unit.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/data_memory_unit.sv
// Byte-addressed little-endian data memory for the LEGv8 memory stage: lane-merged stores
// at the clock edge, combinational zero/sign-extending loads, sticky illegal-access flag.
module data_memory_unit #(
    parameter int N     = 64,
    parameter int DEPTH = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] addr,
    input  logic [N-1:0] wdata,
    input  logic         MemRead,
    input  logic         MemWrite,
    input  logic [1:0]   size,
    input  logic         sign_ext,
    output logic [N-1:0] rdata,
    output logic         misaligned,
    output logic         range_err,
    output logic         error
);
    localparam int IW = $clog2(DEPTH);
    localparam int AW = IW + 3;

    logic [N-1:0]  mem_q [DEPTH];
    logic [N-1:0]  mem_d [DEPTH];
    logic          error_q, error_d;

    logic [IW-1:0] idx;
    logic [2:0]    off;
    logic [5:0]    sh;
    logic          legal;
    logic [7:0]    lane_base, lane_en;
    logic [N-1:0]  bit_en, wdata_sh, word, word_sh;

    assign idx       = addr[AW-1:3];
    assign off       = addr[2:0];
    assign sh        = {off, 3'b000};
    assign range_err = |addr[N-1:AW];
    assign legal     = !misaligned && !range_err;
    assign word      = mem_q[idx];
    assign word_sh   = word >> sh;
    assign wdata_sh  = wdata << sh;
    assign error     = error_q;

    always_comb begin
        misaligned = 1'b0;
        case (size)
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = addr[0];
            2'b10:   misaligned = |addr[1:0];
            default: misaligned = |addr[2:0];
        endcase
    end

    // Legal accesses never cross a doubleword, so the lane mask shifts without wrapping.
    always_comb begin
        lane_base = 8'h00;
        case (size)
            2'b00:   lane_base = 8'h01;
            2'b01:   lane_base = 8'h03;
            2'b10:   lane_base = 8'h0F;
            default: lane_base = 8'hFF;
        endcase
        lane_en = lane_base << off;
        bit_en  = '0;
        for (int b = 0; b < 8; b++) begin
            bit_en[8*b +: 8] = {8{lane_en[b]}};
        end
    end

    always_comb begin
        rdata = '0;
        if (MemRead && legal) begin
            case (size)
                2'b00:   rdata = {{(N-8){sign_ext & word_sh[7]}},   word_sh[7:0]};
                2'b01:   rdata = {{(N-16){sign_ext & word_sh[15]}}, word_sh[15:0]};
                2'b10:   rdata = {{(N-32){sign_ext & word_sh[31]}}, word_sh[31:0]};
                default: rdata = word_sh;
            endcase
        end
    end

    always_comb begin
        mem_d = mem_q;
        if (MemWrite && legal) begin
            mem_d[idx] = (word & ~bit_en) | (wdata_sh & bit_en);
        end
        error_d = error_q | ((MemRead | MemWrite) & ~legal);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            error_q <= 1'b0;
        end else begin
            mem_q   <= mem_d;
            error_q <= error_d;
        end
    end
endmodule

// File: tb/tb_data_memory_unit.sv
// Bench for data_memory_unit: byte-array reference model checked every cycle plus directed literals.
module tb_data_memory_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] addr, wdata;
    logic        MemRead, MemWrite, sign_ext;
    logic [1:0]  size;
    logic [63:0] rdata;
    logic        misaligned, range_err, error;

    int vectors = 0;
    int miscompares = 0;
    bit cmp_en = 1'b0;

    logic [7:0] mbytes [0:255];
    logic       merr;

    data_memory_unit #(.N(64), .DEPTH(32)) dut (
        .clk(clk), .reset(reset), .addr(addr), .wdata(wdata),
        .MemRead(MemRead), .MemWrite(MemWrite), .size(size), .sign_ext(sign_ext),
        .rdata(rdata), .misaligned(misaligned), .range_err(range_err), .error(error)
    );

    always #5 clk = ~clk;

    function automatic bit m_mis(input logic [63:0] a, input logic [1:0] s);
        return (a % (64'd1 << s)) != 64'd0;
    endfunction

    function automatic bit m_rng(input logic [63:0] a);
        return a >= 64'd256;
    endfunction

    function automatic logic [63:0] m_rdata();
        logic [63:0] v;
        int n;
        v = '0;
        if (!MemRead || m_mis(addr, size) || m_rng(addr)) return '0;
        n = 1 << size;
        for (int k = 0; k < n; k++) v = v | (64'(mbytes[int'(addr[7:0]) + k]) << (8 * k));
        if (sign_ext && n < 8 && v[8*n-1]) v = v | ~((64'd1 << (8 * n)) - 64'd1);
        return v;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 256; i++) mbytes[i] = 8'h00;
            merr = 1'b0;
        end else begin
            if ((MemRead || MemWrite) && (m_mis(addr, size) || m_rng(addr))) merr = 1'b1;
            if (MemWrite && !m_mis(addr, size) && !m_rng(addr))
                for (int k = 0; k < (1 << size); k++) mbytes[int'(addr[7:0]) + k] = wdata[8*k +: 8];
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("model_rdata", rdata, m_rdata());
            chk("model_misaligned", 64'(misaligned), 64'(m_mis(addr, size)));
            chk("model_range_err", 64'(range_err), 64'(m_rng(addr)));
            chk("model_error", 64'(error), 64'(merr));
        end
    end

    task automatic drive(input bit rd, input bit wr, input logic [63:0] a, input logic [1:0] s,
                         input bit sx, input logic [63:0] wd);
        MemRead = rd; MemWrite = wr; addr = a; size = s; sign_ext = sx; wdata = wd;
    endtask

    task automatic settle();
        @(negedge clk); #1;
    endtask

    task automatic edge_step();
        @(posedge clk); #1;
    endtask

    initial begin
        reset = 1'b0;
        drive(0, 0, 64'h0, 2'b00, 0, 64'h0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        cmp_en = 1'b1;

        // Test 1: every word reads zero after reset.
        for (int i = 0; i < 32; i++) begin
            drive(1, 0, 64'(i * 8), 2'b11, 0, 64'h0);
            settle();
            chk("reset_word", rdata, 64'h0);
            edge_step();
        end
        chk("reset_error", 64'(error), 64'h0);

        // Test 2: doubleword store and loads.
        drive(0, 1, 64'h10, 2'b11, 0, 64'h8877665544332211);
        edge_step();
        drive(1, 0, 64'h10, 2'b11, 0, 64'h0);
        settle();
        chk("ldur_10", rdata, 64'h8877665544332211);
        drive(1, 0, 64'h17, 2'b00, 0, 64'h0);
        settle();
        chk("ldurb_17_zx", rdata, 64'h88);
        drive(1, 0, 64'h17, 2'b00, 1, 64'h0);
        settle();
        chk("ldurb_17_sx", rdata, 64'hFFFFFFFFFFFFFF88);
        drive(1, 0, 64'h12, 2'b01, 1, 64'h0);
        settle();
        chk("ldurh_12_sx", rdata, 64'h0000000000004433);
        drive(1, 0, 64'h14, 2'b10, 1, 64'h0);
        settle();
        chk("ldurw_14_sx", rdata, 64'hFFFFFFFF88776655);
        edge_step();

        // Test 3: single-byte store into lane 3.
        drive(0, 1, 64'h13, 2'b00, 0, 64'hFFFFFFFFFFFFFFAB);
        edge_step();
        drive(1, 0, 64'h10, 2'b11, 0, 64'h0);
        settle();
        chk("byte_merge", rdata, 64'h88776655AB332211);
        edge_step();

        // Test 4: misaligned stores are rejected and flag error.
        drive(0, 1, 64'h21, 2'b01, 0, 64'hFFFF);
        settle();
        chk("mis_half", 64'(misaligned), 64'h1);
        edge_step();
        chk("mis_err_first", 64'(error), 64'h1);
        drive(0, 1, 64'h22, 2'b10, 0, 64'hFFFFFFFF);
        settle();
        chk("mis_word", 64'(misaligned), 64'h1);
        edge_step();
        drive(0, 1, 64'h0C, 2'b11, 0, 64'hFFFFFFFFFFFFFFFF);
        settle();
        chk("mis_dword", 64'(misaligned), 64'h1);
        edge_step();
        drive(1, 0, 64'h20, 2'b11, 0, 64'h0);
        settle();
        chk("mis_word4_kept", rdata, 64'h0);
        drive(1, 0, 64'h08, 2'b11, 0, 64'h0);
        settle();
        chk("mis_word1_kept", rdata, 64'h0);
        edge_step();

        // Test 5: out-of-range load.
        drive(1, 0, 64'h100, 2'b11, 0, 64'h0);
        settle();
        chk("rng_flag", 64'(range_err), 64'h1);
        chk("rng_rdata", rdata, 64'h0);
        edge_step();
        chk("rng_error", 64'(error), 64'h1);

        // Reset pulse during a store clears memory and the sticky flag.
        drive(0, 1, 64'h08, 2'b11, 0, 64'hDEADBEEFCAFEF00D);
        edge_step();
        drive(1, 0, 64'h08, 2'b11, 0, 64'h0);
        settle();
        chk("pre_reset_word1", rdata, 64'hDEADBEEFCAFEF00D);
        edge_step();
        drive(0, 1, 64'h08, 2'b11, 0, 64'h1234567812345678);
        #2 reset = 1'b0;
        edge_step();
        reset = 1'b1;
        drive(1, 0, 64'h08, 2'b11, 0, 64'h0);
        settle();
        chk("post_reset_word1", rdata, 64'h0);
        chk("post_reset_error", 64'(error), 64'h0);
        edge_step();

        // Test 6: simultaneous read and write of one word.
        drive(0, 1, 64'h18, 2'b11, 0, 64'h5);
        edge_step();
        drive(1, 1, 64'h18, 2'b11, 0, 64'h1);
        settle();
        chk("rw_before", rdata, 64'h5);
        edge_step();
        drive(1, 0, 64'h18, 2'b11, 0, 64'h1);
        settle();
        chk("rw_after", rdata, 64'h1);
        edge_step();

        cmp_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
